// File: rtl/humidity_pkg.sv
// rtl/humidity_pkg.sv - shared frame layout, limits, defaults and slew state encoding for the vent controller
package humidity_pkg;

    localparam int RH_INT_MSB = 39;
    localparam int RH_INT_LSB = 32;
    localparam int RH_DEC_MSB = 31;
    localparam int RH_DEC_LSB = 24;
    localparam int T_INT_MSB  = 23;
    localparam int T_INT_LSB  = 16;
    localparam int T_DEC_MSB  = 15;
    localparam int T_DEC_LSB  = 8;
    localparam int CSUM_MSB   = 7;
    localparam int CSUM_LSB   = 0;

    localparam int RH_MAX = 100;

    localparam int DEF_ON_DUTY    = 200;
    localparam int DEF_FAULT_DUTY = 128;
    localparam int DEF_RAMP_DIV   = 4000;
    localparam int DEF_RAMP_STEP  = 1;
    localparam int DEF_MAX_BAD    = 3;
    localparam int DEF_STALE_CYC  = 12000000;

    typedef enum logic [1:0] {
        SLEW_OFF  = 2'd0,
        SLEW_UP   = 2'd1,
        SLEW_HOLD = 2'd2,
        SLEW_DOWN = 2'd3
    } slew_state_e;

    // Slew state is purely the relation between the output duty and where it is heading.
    function automatic slew_state_e classify_slew(input logic [7:0] duty, input logic [7:0] target);
        slew_state_e s;
        if (duty < target) begin
            s = SLEW_UP;
        end else if (duty > target) begin
            s = SLEW_DOWN;
        end else if (duty == 8'd0) begin
            s = SLEW_OFF;
        end else begin
            s = SLEW_HOLD;
        end
        return s;
    endfunction

endpackage

// File: rtl/dht_frame_check.sv
// rtl/dht_frame_check.sv - checksum/range validation of a sensor frame; registers the reject pulse and last good RH
module dht_frame_check
    import humidity_pkg::*;
(
    input  logic        clk1M,
    input  logic        rst,
    input  logic        frame_valid,
    input  logic [39:0] frame,
    output logic        good_o,
    output logic        bad_o,
    output logic [7:0]  rh_int_o,
    output logic        crc_err_o,
    output logic [7:0]  hum_last_o
);

    logic [7:0] sum;
    logic       frame_ok;
    logic       crc_err_q;
    logic [7:0] hum_last_q;

    assign rh_int_o = frame[RH_INT_MSB:RH_INT_LSB];
    assign sum      = frame[RH_INT_MSB:RH_INT_LSB] + frame[RH_DEC_MSB:RH_DEC_LSB]
                    + frame[T_INT_MSB:T_INT_LSB]   + frame[T_DEC_MSB:T_DEC_LSB];
    assign frame_ok = (sum == frame[CSUM_MSB:CSUM_LSB]) && (rh_int_o <= 8'(RH_MAX));
    assign good_o   = frame_valid & frame_ok;
    assign bad_o    = frame_valid & ~frame_ok;

    always_ff @(posedge clk1M) begin
        if (rst) begin
            crc_err_q  <= 1'b0;
            hum_last_q <= 8'd0;
        end else begin
            crc_err_q <= bad_o;
            if (good_o) begin
                hum_last_q <= rh_int_o;
            end
        end
    end

    assign crc_err_o  = crc_err_q;
    assign hum_last_o = hum_last_q;

endmodule

// File: rtl/humidity_vent_ctrl.sv
// rtl/humidity_vent_ctrl.sv - RH hysteresis, sensor-fault tracking and slew-limited vent duty
module humidity_vent_ctrl
    import humidity_pkg::*;
#(
    parameter int ON_DUTY    = DEF_ON_DUTY,
    parameter int FAULT_DUTY = DEF_FAULT_DUTY,
    parameter int RAMP_DIV   = DEF_RAMP_DIV,
    parameter int RAMP_STEP  = DEF_RAMP_STEP,
    parameter int MAX_BAD    = DEF_MAX_BAD,
    parameter int STALE_CYC  = DEF_STALE_CYC
)
(
    input  logic        clk1M,
    input  logic        rst,
    input  logic        frame_valid,
    input  logic [39:0] frame,
    input  logic [7:0]  hum_on,
    input  logic [7:0]  hum_off,
    input  logic        manual_en,
    input  logic [7:0]  manual_duty,
    output logic [7:0]  duty,
    output logic        vent_on,
    output logic [7:0]  hum_last,
    output logic        crc_err,
    output logic        sensor_fault,
    output logic [1:0]  state
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int BW = $clog2(MAX_BAD + 1);

    localparam logic [7:0]    ON8    = 8'(ON_DUTY);
    localparam logic [7:0]    FAULT8 = 8'(FAULT_DUTY);
    localparam logic [7:0]    STEP8  = 8'(RAMP_STEP);
    localparam logic [8:0]    STEP9  = 9'(RAMP_STEP);
    localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);
    localparam logic [BW-1:0] BAD_LIM  = BW'(MAX_BAD);
    localparam logic [23:0]   STALE_LIM = 24'(STALE_CYC);

    logic        good, bad;
    logic [7:0]  rh_int;

    logic [7:0]    duty_q, duty_d;
    logic          vent_on_q, vent_on_d;
    logic          fault_q, fault_d;
    logic [BW-1:0] bad_cnt_q, bad_cnt_d;
    logic [23:0]   stale_q, stale_d;
    logic [PW-1:0] pres_q, pres_d;
    slew_state_e   state_q, state_d;

    logic        tick;
    logic [7:0]  target, target_next;
    logic [8:0]  duty9, tgt9;

    dht_frame_check u_check (
        .clk1M       (clk1M),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame       (frame),
        .good_o      (good),
        .bad_o       (bad),
        .rh_int_o    (rh_int),
        .crc_err_o   (crc_err),
        .hum_last_o  (hum_last)
    );

    function automatic logic [7:0] pick_target(input logic man, input logic [7:0] md,
                                               input logic flt, input logic vent);
        logic [7:0] t;
        if (man) begin
            t = md;
        end else if (flt) begin
            t = FAULT8;
        end else if (vent) begin
            t = ON8;
        end else begin
            t = 8'd0;
        end
        return t;
    endfunction

    assign tick   = (pres_q == PRE_LAST);
    assign target = pick_target(manual_en, manual_duty, fault_q, vent_on_q);
    assign duty9  = {1'b0, duty_q};
    assign tgt9   = {1'b0, target};

    always_comb begin
        vent_on_d = vent_on_q;
        fault_d   = fault_q;
        bad_cnt_d = bad_cnt_q;
        stale_d   = stale_q;
        // A good frame outranks both the bad-frame and staleness paths in the same cycle.
        if (good) begin
            bad_cnt_d = '0;
            stale_d   = 24'd0;
            fault_d   = 1'b0;
            if (rh_int >= hum_on) begin
                vent_on_d = 1'b1;
            end else if (rh_int <= hum_off) begin
                vent_on_d = 1'b0;
            end
        end else begin
            if (stale_q != STALE_LIM) begin
                stale_d = stale_q + 24'd1;
            end
            if (bad && (bad_cnt_q != BAD_LIM)) begin
                bad_cnt_d = bad_cnt_q + 1'b1;
            end
            if ((bad && (bad_cnt_d == BAD_LIM)) || (stale_d == STALE_LIM)) begin
                fault_d = 1'b1;
            end
        end
    end

    always_comb begin
        pres_d = tick ? '0 : pres_q + 1'b1;
        duty_d = duty_q;
        // 9-bit compares keep the step from wrapping past either rail.
        if (tick) begin
            if (duty9 < tgt9) begin
                duty_d = (duty9 + STEP9 <= tgt9) ? duty_q + STEP8 : target;
            end else if (duty9 > tgt9) begin
                duty_d = (duty9 >= tgt9 + STEP9) ? duty_q - STEP8 : target;
            end
        end
        target_next = pick_target(manual_en, manual_duty, fault_d, vent_on_d);
        state_d     = classify_slew(duty_d, target_next);
    end

    always_ff @(posedge clk1M) begin
        if (rst) begin
            duty_q    <= 8'd0;
            vent_on_q <= 1'b0;
            fault_q   <= 1'b0;
            bad_cnt_q <= '0;
            stale_q   <= 24'd0;
            pres_q    <= '0;
            state_q   <= SLEW_OFF;
        end else begin
            duty_q    <= duty_d;
            vent_on_q <= vent_on_d;
            fault_q   <= fault_d;
            bad_cnt_q <= bad_cnt_d;
            stale_q   <= stale_d;
            pres_q    <= pres_d;
            state_q   <= state_d;
        end
    end

    assign duty         = duty_q;
    assign vent_on      = vent_on_q;
    assign sensor_fault = fault_q;
    assign state        = state_q;

endmodule
